// File: rtl/keypad_key_injector.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_key_injector
//  Purpose  : Keypad-side responder for the 4x4 row-sweep scanner. Accepts
//             one key code at a time (keypad encoder code space), then
//             answers the scanner's one-hot row drive with the matching
//             one-hot column pattern for HOLD_CYCLES clocks, followed by a
//             forced release of GAP_CYCLES clocks.
//
//  Ports    :
//    clk        in   1  clock
//    rst        in   1  asynchronous active-high reset
//    key_code   in   8  key to press (encoder code space)
//    key_valid  in   1  press request, sampled only while key_ready=1
//    row_in     in   4  scanner row drive, one-hot active-high
//    col_out    out  4  column lines to scanner, one-hot, 0 = no key
//    key_ready  out  1  high while idle
//    busy       out  1  high while pressing or releasing
//    done       out  1  single-cycle pulse on return to idle
//    hit        out  1  qualified by done: row match seen during the press
//    err        out  1  single-cycle pulse on an illegal key_code request
//
//  Options  : define KEYINJ_BOUNCE_EN to gate the column drive on odd
//             counter values during the first BOUNCE_CYCLES press cycles
//             (contact-bounce model). Without it the press is clean and
//             BOUNCE_CYCLES has no effect.
//
//  Revision : 1.0 - initial release
// ============================================================================
module keypad_key_injector #(
    parameter int HOLD_CYCLES   = 1000000,
    parameter int GAP_CYCLES    = 1000000,
    parameter int CNT_W         = 24,
    parameter int BOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_code,
    input  logic       key_valid,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_ready,
    output logic       busy,
    output logic       done,
    output logic       hit,
    output logic       err
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] BOUNCE_LIM = CNT_W'(BOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

`ifdef KEYINJ_BOUNCE_EN
    localparam bit BOUNCE_ON = 1'b1;
`else
    localparam bit BOUNCE_ON = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESS   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       col_lat;
    logic [3:0]       row_lat;
    logic             hit_flag;

    // ------------------------------------------------------------------
    // Key decode: key_code -> {col, row}. Digits sit in the lower three
    // rows; operators are already encoded as {col,row} and map to
    // themselves.
    // ------------------------------------------------------------------
    logic [3:0] dec_col;
    logic [3:0] dec_row;
    logic       dec_legal;

    always_comb begin
        dec_col   = 4'b0000;
        dec_row   = 4'b0000;
        dec_legal = 1'b1;
        case (key_code)
            8'h00: {dec_col, dec_row} = 8'b1000_0001;
            8'h01: {dec_col, dec_row} = 8'b0100_0001;
            8'h02: {dec_col, dec_row} = 8'b0100_0010;
            8'h03: {dec_col, dec_row} = 8'b0100_0100;
            8'h04: {dec_col, dec_row} = 8'b0010_0001;
            8'h05: {dec_col, dec_row} = 8'b0010_0010;
            8'h06: {dec_col, dec_row} = 8'b0010_0100;
            8'h07: {dec_col, dec_row} = 8'b0001_0001;
            8'h08: {dec_col, dec_row} = 8'b0001_0010;
            8'h09: {dec_col, dec_row} = 8'b0001_0100;
            8'h82: {dec_col, dec_row} = 8'b1000_0010; // add
            8'h84: {dec_col, dec_row} = 8'b1000_0100; // sub
            8'h88: {dec_col, dec_row} = 8'b1000_1000; // mult
            8'h18: {dec_col, dec_row} = 8'b0001_1000; // clear
            8'h48: {dec_col, dec_row} = 8'b0100_1000; // equal
            8'h28: {dec_col, dec_row} = 8'b0010_1000; // divide
            default: dec_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Row match. The latched row is always one-hot, so an exact compare
    // automatically rejects any row_in that is not one-hot.
    // ------------------------------------------------------------------
    logic row_match;
    logic bounce_gate;
    logic drive;

    always_comb begin
        row_match   = (row_in == row_lat);
        // Odd counter values inside the bounce window open the contact.
        bounce_gate = BOUNCE_ON && (cnt < BOUNCE_LIM) && cnt[0];
        drive       = row_match && !bounce_gate;
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            col_lat   <= 4'b0000;
            row_lat   <= 4'b0000;
            hit_flag  <= 1'b0;
            col_out   <= 4'b0000;
            key_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            hit       <= 1'b0;
            err       <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle.
            done <= 1'b0;
            hit  <= 1'b0;
            err  <= 1'b0;

            case (state)
                IDLE: begin
                    col_out <= 4'b0000;
                    if (key_valid) begin
                        if (dec_legal) begin
                            col_lat   <= dec_col;
                            row_lat   <= dec_row;
                            cnt       <= '0;
                            hit_flag  <= 1'b0;
                            state     <= PRESS;
                            key_ready <= 1'b0;
                            busy      <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                PRESS: begin
                    // One clock of latency from row_in to col_out.
                    col_out <= drive ? col_lat : 4'b0000;
                    if (drive) begin
                        hit_flag <= 1'b1;
                    end
                    if (cnt == HOLD_LAST) begin
                        cnt   <= '0;
                        state <= RELEASE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                RELEASE: begin
                    col_out <= 4'b0000;
                    if (cnt == GAP_LAST) begin
                        cnt       <= '0;
                        state     <= IDLE;
                        done      <= 1'b1;
                        hit       <= hit_flag;
                        key_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    // Unreachable encoding: recover to idle quietly.
                    state     <= IDLE;
                    cnt       <= '0;
                    col_out   <= 4'b0000;
                    key_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_key_injector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_key_injector
//  Purpose  : Directed self-checking bench for keypad_key_injector
//             (HOLD_CYCLES=10, GAP_CYCLES=4, BOUNCE_CYCLES=8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_key_injector;

    localparam int HOLD = 10;
    localparam int GAP  = 4;
    localparam int BNC  = 8;

`ifdef KEYINJ_BOUNCE_EN
    localparam bit GATED = 1'b1;
`else
    localparam bit GATED = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] key_code;
    logic       key_valid;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       key_ready;
    logic       busy;
    logic       done;
    logic       hit;
    logic       err;

    int n_vec = 0;
    int n_bad = 0;

    keypad_key_injector #(
        .HOLD_CYCLES  (HOLD),
        .GAP_CYCLES   (GAP),
        .CNT_W        (8),
        .BOUNCE_CYCLES(BNC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_code (key_code),
        .key_valid(key_valid),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_ready(key_ready),
        .busy     (busy),
        .done     (done),
        .hit      (hit),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after
    // the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Row pattern for window w: mode 0 holds row_c, mode 1 rotates
    // 1000 -> 0100 -> 0010 -> 0001 starting at w=0.
    function automatic logic [3:0] row_pat(input int mode, input logic [3:0] row_c, input int w);
        logic [3:0] r;
        r = 4'b1000;
        if (mode == 0) return row_c;
        return r >> (w % 4);
    endfunction

    // Full press/release transaction with a cycle-by-cycle column model.
    task automatic run_key(input string name, input logic [7:0] code,
                           input logic [3:0] exp_col, input logic [3:0] exp_row,
                           input int mode, input logic [3:0] row_c, input bit gated);
        logic [3:0] exp;
        logic       exp_hit;
        exp_hit   = 1'b0;
        key_code  = code;
        key_valid = 1'b1;
        row_in    = row_pat(mode, row_c, 0);
        tick();
        key_valid = 1'b0;
        key_code  = 8'hFF;
        n_vec++;
        if (busy !== 1'b1 || key_ready !== 1'b0 || col_out !== 4'b0000) begin
            n_bad++;
            $display("FAIL %s accept: busy=%b ready=%b col=%b, want busy=1 ready=0 col=0000",
                     name, busy, key_ready, col_out);
        end
        for (int w = 0; w < HOLD; w++) begin
            row_in = row_pat(mode, row_c, w);
            exp = 4'b0000;
            if (row_in == exp_row && !(gated && w < BNC && (w % 2) == 1)) begin
                exp     = exp_col;
                exp_hit = 1'b1;
            end
            tick();
            n_vec++;
            if (col_out !== exp || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL %s hold[%0d]: col=%b busy=%b, want col=%b busy=1",
                         name, w, col_out, busy, exp);
            end
        end
        for (int g = 0; g < GAP - 1; g++) begin
            row_in = exp_row;   // matching row must still be ignored
            tick();
            n_vec++;
            if (col_out !== 4'b0000 || done !== 1'b0) begin
                n_bad++;
                $display("FAIL %s gap[%0d]: col=%b done=%b, want col=0000 done=0",
                         name, g, col_out, done);
            end
        end
        tick();
        n_vec++;
        if (done !== 1'b1 || hit !== exp_hit || key_ready !== 1'b1 || busy !== 1'b0 ||
            col_out !== 4'b0000) begin
            n_bad++;
            $display("FAIL %s done: done=%b hit=%b ready=%b busy=%b col=%b, want 1 %b 1 0 0000",
                     name, done, hit, key_ready, busy, col_out, exp_hit);
        end
        tick();
        n_vec++;
        if (done !== 1'b0 || hit !== 1'b0 || key_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s after_done: done=%b hit=%b ready=%b, want 0 0 1",
                     name, done, hit, key_ready);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        key_code  = 8'h00;
        key_valid = 1'b0;
        row_in    = 4'b0000;
        tick();
        tick();
        n_vec++;
        if (col_out !== 4'b0000 || key_ready !== 1'b1 || busy !== 1'b0 ||
            done !== 1'b0 || hit !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: col=%b ready=%b busy=%b done=%b hit=%b err=%b, want 0000 1 0 0 0 0",
                     col_out, key_ready, busy, done, hit, err);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_illegal(input logic [7:0] code);
        key_code  = code;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        n_vec++;
        if (err !== 1'b1 || key_ready !== 1'b1 || busy !== 1'b0 || col_out !== 4'b0000) begin
            n_bad++;
            $display("FAIL illegal_%h: err=%b ready=%b busy=%b col=%b, want 1 1 0 0000",
                     code, err, key_ready, busy, col_out);
        end
        tick();
        n_vec++;
        if (err !== 1'b0 || key_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal_%h_pulse: err=%b ready=%b busy=%b, want 0 1 0",
                     code, err, key_ready, busy);
        end
    endtask

    task automatic test_reset_mid_press();
        bit saw_done;
        key_code  = 8'h00;
        key_valid = 1'b1;
        row_in    = 4'b0001;
        tick();                       // accepted, PRESS
        key_valid = 1'b0;
        for (int w = 0; w < 6; w++) begin
            if (w == 2) begin
                key_code  = 8'h09;    // must be ignored while busy
                key_valid = 1'b1;
            end else begin
                key_valid = 1'b0;
            end
            tick();
        end
        key_valid = 1'b0;
        n_vec++;
        if (col_out !== 4'b1000 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL midrst_pre: col=%b busy=%b, want 1000 1", col_out, busy);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (col_out !== 4'b0000 || key_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_async: col=%b ready=%b busy=%b, want 0000 1 0",
                     col_out, key_ready, busy);
        end
        tick();
        rst = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < HOLD + GAP + 4; c++) begin
            tick();
            if (done !== 1'b0 || col_out !== 4'b0000) saw_done = 1'b1;
        end
        n_vec++;
        if (saw_done || key_ready !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_after: spurious=%b ready=%b busy=%b, want 0 1 0",
                     saw_done, key_ready, busy);
        end
    endtask

    initial begin
        test_reset();
        run_key("key05_row0010", 8'h05, 4'b0010, 4'b0010, 0, 4'b0010, GATED);
        run_key("key48_rotate",  8'h48, 4'b0100, 4'b1000, 1, 4'b0000, GATED);
        run_key("key07_nomatch", 8'h07, 4'b0001, 4'b0001, 0, 4'b0100, GATED);
        run_key("key05_multihot", 8'h05, 4'b0010, 4'b0010, 0, 4'b0110, GATED);
        test_illegal(8'h0A);
        test_illegal(8'h81);
        test_reset_mid_press();
        run_key("key01_bounce",  8'h01, 4'b0100, 4'b0001, 0, 4'b0001, GATED);
        // back-to-back: next request lands right after the previous done
        run_key("key88_b2b",     8'h88, 4'b1000, 4'b1000, 1, 4'b0000, GATED);
        run_key("key18_clear",   8'h18, 4'b0001, 4'b1000, 0, 4'b1000, GATED);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
